// File: rtl/pending_encoder_if.sv
// Handshake bundle between a request source/code consumer and the pending encoder.
// The master modport is the environment side; the encoder itself uses the slave modport.
interface pending_encoder_if;
   logic       load;
   logic [7:0] d;
   logic [2:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       busy;
   logic       done;
   logic       none;
   logic       multi;
   logic [3:0] count;

   modport master (
      output load, d, code_ready,
      input  code, code_valid, busy, done, none, multi, count
   );

   modport slave (
      input  load, d, code_ready,
      output code, code_valid, busy, done, none, multi, count
   );
endinterface

// File: rtl/pending_encoder.sv
// Captures an 8-bit request vector and drains it as one binary code per accepted
// transfer, lowest or highest set index first, then pulses done for one cycle.
module pending_encoder #(
   parameter bit LSB_FIRST = 1'b1
) (
   input logic               clk,
   input logic               rst,
   pending_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] p_q, p_d;
   logic [3:0] count_q, count_d;
   logic       none_q, none_d;
   logic       multi_q, multi_d;

   logic [2:0] sel;
   logic [7:0] p_clr;
   logic       xfer;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (v[k]) idx = 3'(k);
      end
      return idx;
   endfunction

   function automatic logic [2:0] highest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (v[k]) idx = 3'(k);
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   function automatic logic many_set(input logic [7:0] v);
      return (v & (v - 8'd1)) != 8'd0;
   endfunction

   // An empty P encodes to 0, so code reads 0 whenever nothing is pending.
   assign sel   = LSB_FIRST ? lowest_set(p_q) : highest_set(p_q);
   assign p_clr = p_q & ~(8'd1 << sel);
   assign xfer  = (state_q == EMIT) && bus.code_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= 8'd0;
         count_q <= 4'd0;
         none_q  <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         count_q <= count_d;
         none_q  <= none_d;
         multi_q <= multi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      count_d = count_q;
      none_d  = none_q;
      multi_d = multi_q;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               p_d     = bus.d;
               count_d = 4'd0;
               none_d  = (bus.d == 8'd0);
               multi_d = many_set(bus.d);
               state_d = (bus.d != 8'd0) ? EMIT : FIN;
            end
         end
         EMIT: begin
            if (xfer) begin
               p_d     = p_clr;
               count_d = count_q + 4'd1;
               if (p_clr == 8'd0) state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.code       = sel;
   assign bus.code_valid = (state_q == EMIT);
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == FIN);
   assign bus.none       = none_q;
   assign bus.multi      = multi_q;
   assign bus.count      = count_q;

endmodule

// File: doc/pending_encoder.md
PENDING_ENCODER -- requirements
Module: pending_encoder

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = lowest set index emitted first, 0 = highest set index emitted first.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port load, input, 1, request to capture d when idle.
REQ-005 SHALL have port d, input, 8, request vector; d[k] set means code k is pending.
REQ-006 SHALL have port code, output, 3, binary index of the currently presented pending bit.
REQ-007 SHALL have port code_valid, output, 1, code is valid for transfer.
REQ-008 SHALL have port code_ready, input, 1, consumer accepts code.
REQ-009 SHALL have port busy, output, 1, high from capture until the last code transfers.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a captured vector is fully drained.
REQ-011 SHALL have port none, output, 1, registered flag: last captured vector was all zero.
REQ-012 SHALL have port multi, output, 1, registered flag: last captured vector had two or more bits set (not one-hot).
REQ-013 SHALL have port count, output, 4, number of codes transferred for the current/last vector (0..8).

Function
REQ-014 SHALL be a three-state FSM: IDLE, EMIT, FIN.
REQ-015 IDLE: load=1 SHALL capture d into 8-bit pending register P, clear count, set none=(d==0), set multi=(popcount(d)>=2), go to EMIT if d!=0, else FIN.
REQ-016 load SHALL be ignored outside IDLE; d changes outside IDLE SHALL have no effect.
REQ-017 EMIT: code_valid SHALL be 1; code SHALL be the lowest set index of P (LSB_FIRST=1) or the highest set index (LSB_FIRST=0), derived combinationally from registered P.
REQ-018 Transfer SHALL occur on a cycle where code_valid and code_ready are both 1; on transfer P[code] SHALL clear and count SHALL increment.
REQ-019 After a transfer with remaining P!=0, code_valid SHALL stay 1 and code SHALL show the next index in the following cycle (one code per cycle at full throughput).
REQ-020 code and code_valid SHALL hold stable while code_ready=0 (no drop, no change).
REQ-021 Transfer of the last set bit SHALL move to FIN; FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 Latency: load at edge N SHALL give code_valid=1 after edge N; all-zero load SHALL give done=1 after edge N and code_valid=0 throughout.
REQ-023 busy SHALL be 1 in EMIT and FIN, 0 in IDLE; code_valid SHALL be 0 outside EMIT.
REQ-024 count SHALL saturate at 8 by construction (at most 8 transfers); none, multi, count SHALL hold after done until the next accepted load.
REQ-025 Back-to-back: load asserted in the cycle done is high SHALL be ignored; load in the following IDLE cycle SHALL be accepted.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, P=0, code=0, code_valid=0, busy=0, done=0, none=0, multi=0, count=0.
REQ-027 Reset asserted mid-EMIT SHALL discard pending bits; no done pulse SHALL follow.
REQ-028 After rst deasserts, the first load SHALL be accepted on the first rising clk edge.

Verification
REQ-029 LSB_FIRST=1, d=8'b1000_0000 (d7 only), code_ready=1 -> one code=7, done one cycle later, multi=0, none=0, count=1.
REQ-030 LSB_FIRST=1, d=8'b1010_0101, code_ready=1 -> codes 0,2,5,7 on consecutive cycles, done, multi=1, count=4.
REQ-031 LSB_FIRST=0, d=8'hFF, code_ready toggling 1/0 -> codes 7..0 in order, each held stable while ready=0, count=8.
REQ-032 d=8'h00 load -> code_valid never 1, done pulse next cycle, none=1, count=0.
REQ-033 Sweep one-hot d=1<<k for k=0..7 (mirrors decoder outputs d0..d7) -> single code=k each, multi=0.
REQ-034 rst pulse after second transfer of d=8'hF0 -> outputs zero immediately, no done; subsequent load d=8'h01 gives code=0.
